// File: rtl/width_change_ctrl_pkg.sv
// Shared defaults and FSM encoding for the 16->24-bit width change sequencer.
package width_change_ctrl_pkg;

    localparam int DEF_QUAN_BITS       = 8;
    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_BURST_LEN       = 16;
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_MAX_OUTSTANDING = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/width_change_ctrl_if.sv
// Memory read request/data and converter handshakes seen by the sequencer.
interface width_change_ctrl_if #(
    parameter int QUAN_BITS = width_change_ctrl_pkg::DEF_QUAN_BITS,
    parameter int ADDR_W    = width_change_ctrl_pkg::DEF_ADDR_W,
    parameter int BURST_LEN = width_change_ctrl_pkg::DEF_BURST_LEN
);
    localparam int LEN_W = $clog2(BURST_LEN + 1);

    logic                   o_rd_req_valid;
    logic                   i_rd_req_ready;
    logic [ADDR_W-1:0]      o_rd_req_addr;
    logic [LEN_W-1:0]       o_rd_req_len;
    logic [2*QUAN_BITS-1:0] i_rd_data;
    logic                   i_rd_data_valid;
    logic                   o_rd_data_ready;
    logic [2*QUAN_BITS-1:0] o_cvt_bytes;
    logic                   o_cvt_valid;
    logic                   i_cvt_ready;
    logic                   i_pix_valid;
    logic                   i_pix_ready;

    modport master (
        output o_rd_req_valid, o_rd_req_addr, o_rd_req_len,
        output o_rd_data_ready, o_cvt_bytes, o_cvt_valid,
        input  i_rd_req_ready, i_rd_data, i_rd_data_valid,
        input  i_cvt_ready, i_pix_valid, i_pix_ready
    );

    modport slave (
        input  o_rd_req_valid, o_rd_req_addr, o_rd_req_len,
        input  o_rd_data_ready, o_cvt_bytes, o_cvt_valid,
        output i_rd_req_ready, i_rd_data, i_rd_data_valid,
        output i_cvt_ready, i_pix_valid, i_pix_ready
    );

endinterface

// File: rtl/width_change_ctrl_rd_burst_gen.sv
// Tracks unrequested words and the next burst address; sizes each read burst.
module width_change_ctrl_rd_burst_gen
    import width_change_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = DEF_CNT_W,
    localparam int LEN_W    = $clog2(BURST_LEN + 1)
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  pix_num,
    input  logic              advance,
    output logic [ADDR_W-1:0] req_addr,
    output logic [LEN_W-1:0]  req_len,
    output logic              last
);
    localparam int WORD_W = CNT_W + 1;

    logic [WORD_W-1:0] remaining;
    logic [WORD_W-1:0] word_total;

    // Even pixel counts only: 3 bytes per pixel over 2-byte words = pix + pix/2.
    assign word_total = {1'b0, pix_num} + {2'b00, pix_num[CNT_W-1:1]};

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            remaining <= '0;
            req_addr  <= '0;
        end else if (load) begin
            remaining <= word_total;
            req_addr  <= base_addr;
        end else if (advance) begin
            remaining <= remaining - WORD_W'(req_len);
            req_addr  <= req_addr + (ADDR_W'(req_len) << 1);
        end
    end

    always_comb begin
        req_len = remaining[LEN_W-1:0];
        if (remaining > WORD_W'(BURST_LEN))
            req_len = LEN_W'(BURST_LEN);
    end

    assign last = (remaining <= WORD_W'(BURST_LEN));

endmodule

// File: rtl/width_change_ctrl.sv
// Sequencer for the 16->24-bit converter: issues split burst reads, forwards
// beats to the converter and signals completion once all pixels are delivered.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for i_start; odd pixel counts rejected with o_err
//   ST_REQ   | read request held valid until i_rd_req_ready
//   ST_WAIT  | more words to request; waiting for an outstanding slot
//   ST_DRAIN | all requests issued; waiting for pixels and bursts to finish
//   ST_DONE  | one-cycle o_done, then back to idle
module width_change_ctrl
    import width_change_ctrl_pkg::*;
#(
    parameter int QUAN_BITS       = DEF_QUAN_BITS,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                s_clk,
    input  logic                s_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [CNT_W-1:0]    i_pix_num,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    width_change_ctrl_if.master bus
);
    localparam int LEN_W = $clog2(BURST_LEN + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    state_t            state;
    logic              req_valid;
    logic [CNT_W-1:0]  pix_num_q;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  pix_cnt_nxt;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  outstanding_nxt;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              start_ok;
    logic              req_hs;
    logic              beat_hs;
    logic              burst_end;
    logic              pix_hs;
    logic              gen_last;
    logic [LEN_W-1:0]  gen_len;
    logic [ADDR_W-1:0] gen_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_ok  = (state == ST_IDLE) && i_start && !i_pix_num[0];
    assign req_hs    = req_valid && bus.i_rd_req_ready;
    assign beat_hs   = bus.i_rd_data_valid && bus.o_rd_data_ready;
    assign burst_end = beat_hs && (outstanding != '0) && ((beat_cnt + 1'b1) == len_fifo[rd_ptr]);
    assign pix_hs    = bus.i_pix_valid && bus.i_pix_ready && o_busy;

    assign pix_cnt_nxt = pix_cnt + CNT_W'(pix_hs);

    always_comb begin
        outstanding_nxt = outstanding;
        case ({req_hs, burst_end})
            2'b10:   outstanding_nxt = outstanding + OUT_W'(1);
            2'b01:   outstanding_nxt = outstanding - OUT_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    width_change_ctrl_rd_burst_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_rd_burst_gen (
        .s_clk     (s_clk),
        .s_rst     (s_rst),
        .load      (start_ok),
        .base_addr (i_base_addr),
        .pix_num   (i_pix_num),
        .advance   (req_hs),
        .req_addr  (gen_addr),
        .req_len   (gen_len),
        .last      (gen_last)
    );

    assign bus.o_rd_req_valid  = req_valid;
    assign bus.o_rd_req_addr   = gen_addr;
    assign bus.o_rd_req_len    = gen_len;
    assign bus.o_cvt_bytes     = o_busy ? bus.i_rd_data : '0;
    assign bus.o_cvt_valid     = bus.i_rd_data_valid && o_busy;
    assign bus.o_rd_data_ready = bus.i_cvt_ready && o_busy;

    // Burst lengths are queued so the beat counter knows where the oldest burst ends.
    always_ff @(posedge s_clk) begin
        if (req_hs)
            len_fifo[wr_ptr] <= gen_len;
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            outstanding <= '0;
            beat_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pix_cnt     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            pix_cnt     <= start_ok ? '0 : pix_cnt_nxt;
            if (req_hs)
                wr_ptr <= ptr_inc(wr_ptr);
            if (burst_end) begin
                beat_cnt <= '0;
                rd_ptr   <= ptr_inc(rd_ptr);
            end else if (beat_hs && (outstanding != '0)) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state     <= ST_IDLE;
            req_valid <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            pix_num_q <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_pix_num[0]) begin
                            o_err <= 1'b1;
                        end else begin
                            o_busy    <= 1'b1;
                            pix_num_q <= i_pix_num;
                            if (i_pix_num == '0) begin
                                state  <= ST_DONE;
                                o_done <= 1'b1;
                            end else begin
                                state     <= ST_REQ;
                                req_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.i_rd_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= gen_last ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (outstanding < OUT_W'(MAX_OUTSTANDING)) begin
                        req_valid <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Next-cycle values let o_done follow the last pixel handshake directly.
                    if ((pix_cnt_nxt == pix_num_q) && (outstanding_nxt == '0)) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_width_change_ctrl.sv
// Directed bench for width_change_ctrl with a memory responder and converter model.
module tb_width_change_ctrl;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [19:0] i_pix_num = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    width_change_ctrl_if #(.QUAN_BITS(8), .ADDR_W(32), .BURST_LEN(16)) bus ();

    width_change_ctrl #(
        .QUAN_BITS(8), .ADDR_W(32), .BURST_LEN(16), .CNT_W(20), .MAX_OUTSTANDING(2)
    ) dut (
        .s_clk       (s_clk),
        .s_rst       (s_rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_pix_num   (i_pix_num),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .bus         (bus)
    );

    always #5 s_clk = ~s_clk;

    int tests = 0;
    int fails = 0;

    logic req_rdy_en = 1'b1;
    logic data_en    = 1'b1;
    logic cvt_tog    = 1'b0;
    logic clr        = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } req_t;

    req_t req_log[$];
    req_t pend_q[$];
    int   req_rise[$];
    int   beat_cyc[$];
    int   cyc = 0, beat_idx = 0, beats = 0, conv_beats = 0, pix_pend = 0, pix_hs = 0;
    int   done_cnt = 0, done_cyc = -1, last_pix_cyc = -1, busy_fall_cyc = -1;
    int   data_err = 0, stab_err = 0;
    logic prev_hold = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [4:0]  prev_len = '0;
    logic [15:0] drv_data;
    req_t r;

    // Memory + converter model: drive on the falling edge, observe 1 ns before the rising edge.
    initial begin
        bus.i_rd_req_ready  = 1'b0;
        bus.i_rd_data       = '0;
        bus.i_rd_data_valid = 1'b0;
        bus.i_cvt_ready     = 1'b0;
        bus.i_pix_valid     = 1'b0;
        bus.i_pix_ready     = 1'b0;
        forever begin
            @(negedge s_clk);
            cyc++;
            if (clr || s_rst) begin
                pend_q.delete();
                beat_idx = 0; conv_beats = 0; pix_pend = 0;
            end
            if (clr) begin
                req_log.delete(); req_rise.delete(); beat_cyc.delete();
                beats = 0; pix_hs = 0; done_cnt = 0; done_cyc = -1; last_pix_cyc = -1;
                busy_fall_cyc = -1; data_err = 0; stab_err = 0;
            end
            bus.i_rd_req_ready  = req_rdy_en;
            bus.i_cvt_ready     = cvt_tog ? ~bus.i_cvt_ready : 1'b1;
            bus.i_rd_data_valid = data_en && (pend_q.size() > 0);
            drv_data = (pend_q.size() > 0) ? 16'(pend_q[0].addr >> 1) + 16'(beat_idx) : 16'h0;
            bus.i_rd_data       = drv_data;
            bus.i_pix_valid     = (pix_pend > 0);
            bus.i_pix_ready     = 1'b1;
            #4;
            if (prev_hold && !(bus.o_rd_req_valid && bus.o_rd_req_addr == prev_addr
                               && bus.o_rd_req_len == prev_len))
                stab_err++;
            if (bus.o_rd_req_valid && !prev_valid)
                req_rise.push_back(cyc);
            prev_valid = bus.o_rd_req_valid;
            prev_hold  = bus.o_rd_req_valid && !bus.i_rd_req_ready;
            prev_addr  = bus.o_rd_req_addr;
            prev_len   = bus.o_rd_req_len;
            if (bus.o_rd_req_valid && bus.i_rd_req_ready) begin
                r.addr = bus.o_rd_req_addr;
                r.len  = int'(bus.o_rd_req_len);
                req_log.push_back(r);
                pend_q.push_back(r);
            end
            if (bus.i_rd_data_valid && bus.o_rd_data_ready) begin
                if (bus.o_cvt_bytes !== drv_data || bus.o_cvt_valid !== 1'b1)
                    data_err++;
                beats++;
                beat_cyc.push_back(cyc);
                beat_idx++;
                if (beat_idx == pend_q[0].len) begin
                    void'(pend_q.pop_front());
                    beat_idx = 0;
                end
                conv_beats++;
                if (conv_beats % 3 == 0)
                    pix_pend += 2;
            end
            if (bus.i_pix_valid && bus.i_pix_ready) begin
                pix_pend--;
                pix_hs++;
                last_pix_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !o_busy)
                busy_fall_cyc = cyc;
            prev_busy = o_busy;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge s_clk);
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
    endtask

    task automatic start(input logic [31:0] base, input logic [19:0] pix);
        i_base_addr = base;
        i_pix_num   = pix;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt == 0; i++)
            tick();
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        tick(3);
    endtask

    task automatic check_run(input string tag, input int exp_beats, input int exp_pix);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_cyc, last_pix_cyc + 1);
        check({tag, "_busy_fall"}, busy_fall_cyc, done_cyc + 1);
        check({tag, "_beats"}, beats, exp_beats);
        check({tag, "_pixels"}, pix_hs, exp_pix);
        check({tag, "_data"}, data_err, 0);
        check({tag, "_busy_end"}, o_busy, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {o_busy, o_done, o_err, bus.o_rd_req_valid, bus.o_rd_req_addr,
                    bus.o_rd_req_len, bus.o_cvt_bytes, bus.o_cvt_valid, bus.o_rd_data_ready}, '0);
    endtask

    task automatic run_case1(input string tag);
        clear_stats();
        start(32'h1000, 20'd4);
        check({tag, "_first_valid"}, bus.o_rd_req_valid, 1'b1);
        check({tag, "_busy_rise"}, o_busy, 1'b1);
        check({tag, "_first_addr"}, bus.o_rd_req_addr, 32'h1000);
        check({tag, "_first_len"}, bus.o_rd_req_len, 5'd6);
        wait_done(200, tag);
        check({tag, "_nreq"}, req_log.size(), 1);
        check({tag, "_req0"}, {req_log[0].addr, 32'(req_log[0].len)}, {32'h1000, 32'd6});
        check_run(tag, 6, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_outputs_zero("reset_outputs");
        s_rst = 1'b0;
        tick(2);

        // Case 1: four pixels, single six-beat burst
        run_case1("t1");

        // Case 2: 22 pixels -> 33 words -> 16 + 16 + 1
        clear_stats();
        start(32'h1000, 20'd22);
        wait_done(400, "t2");
        check("t2_nreq", req_log.size(), 3);
        check("t2_req0", {req_log[0].addr, 32'(req_log[0].len)}, {32'h1000, 32'd16});
        check("t2_req1", {req_log[1].addr, 32'(req_log[1].len)}, {32'h1020, 32'd16});
        check("t2_req2", {req_log[2].addr, 32'(req_log[2].len)}, {32'h1040, 32'd1});
        check_run("t2", 33, 22);

        // Case 3: data held off, outstanding limit caps issued requests at two
        clear_stats();
        data_en = 1'b0;
        start(32'h4000, 20'd64);
        tick(20);
        check("t3_nreq_held", req_log.size(), 2);
        check("t3_valid_held", bus.o_rd_req_valid, 1'b0);
        data_en = 1'b1;
        wait_done(800, "t3");
        check("t3_nreq", req_log.size(), 6);
        check("t3_req2", {req_log[2].addr, 32'(req_log[2].len)}, {32'h4040, 32'd16});
        check("t3_req5", {req_log[5].addr, 32'(req_log[5].len)}, {32'h40A0, 32'd16});
        check("t3_third_after_beat16", req_rise[2], beat_cyc[15] + 2);
        check_run("t3", 96, 64);

        // Case 4: request back-pressure and toggling converter ready
        clear_stats();
        req_rdy_en = 1'b0;
        cvt_tog    = 1'b1;
        start(32'h2000, 20'd8);
        tick(5);
        check("t4_valid_hold", bus.o_rd_req_valid, 1'b1);
        check("t4_addr_hold", bus.o_rd_req_addr, 32'h2000);
        check("t4_len_hold", bus.o_rd_req_len, 5'd12);
        req_rdy_en = 1'b1;
        wait_done(300, "t4");
        cvt_tog = 1'b0;
        check("t4_stable", stab_err, 0);
        check("t4_nreq", req_log.size(), 1);
        check("t4_req0", {req_log[0].addr, 32'(req_log[0].len)}, {32'h2000, 32'd12});
        check_run("t4", 12, 8);

        // Case 5: odd count rejected, zero count completes immediately
        clear_stats();
        start(32'h3000, 20'd5);
        check("t5_err_pulse", {o_err, o_busy, bus.o_rd_req_valid}, 3'b100);
        tick();
        check("t5_err_clear", {o_err, o_busy, bus.o_rd_req_valid}, 3'b000);
        start(32'h3000, 20'd0);
        check("t5_zero_done", {o_done, o_busy, bus.o_rd_req_valid}, 3'b110);
        tick();
        check("t5_zero_idle", {o_done, o_busy}, 2'b00);
        tick(2);
        check("t5_nreq", req_log.size(), 0);
        check("t5_done_once", done_cnt, 1);

        // Case 6: reset during the second burst, then a clean restart
        clear_stats();
        start(32'h1000, 20'd22);
        for (int i = 0; i < 300 && !(req_log.size() >= 2 && beats >= 20); i++)
            tick();
        check("t6_in_burst2", 64'(req_log.size() >= 2 && beats >= 20), 64'd1);
        s_rst = 1'b1;
        tick();
        check_outputs_zero("t6_reset_outputs");
        tick();
        s_rst = 1'b0;
        tick(2);
        check("t6_no_done", done_cnt, 0);
        check_outputs_zero("t6_idle_after_reset");
        run_case1("t6r");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/width_change_ctrl.md
# width_change_ctrl

Sequencer for the 16→24-bit pixel width converter. On a start command it reads `i_pix_num` RGB pixels from memory as 16-bit words, issuing split burst read requests with a bounded number outstanding. It forwards the read data to the converter and counts the 24-bit pixels accepted downstream. It pulses `o_done` when the image is fully delivered.

## Interface
- `QUAN_BITS`, 8: bits per colour component; read word = 2·QUAN_BITS, pixel = 3·QUAN_BITS.
- `ADDR_W`, 32: byte address width.
- `BURST_LEN`, 16: max beats (16-bit words) per read request.
- `CNT_W`, 20: pixel counter width.
- `MAX_OUTSTANDING`, 2: max issued-but-incomplete bursts.

Ports:
- `s_clk`  in  1  clock.
- `s_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  start pulse; sampled in IDLE only.
- `i_base_addr`  in  ADDR_W  byte base address, captured with `i_start`.
- `i_pix_num`  in  CNT_W  pixel count, captured with `i_start`.
- `o_busy`  out  1  high from accepted start through DONE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  one-cycle pulse when a start is rejected (odd `i_pix_num`).
- `o_rd_req_valid`  out  1  read request valid.
- `i_rd_req_ready`  in  1  read request accepted.
- `o_rd_req_addr`  out  ADDR_W  burst byte address.
- `o_rd_req_len`  out  $clog2(BURST_LEN+1)  beats in burst, range 1..BURST_LEN.
- `i_rd_data`  in  2·QUAN_BITS  read beat.
- `i_rd_data_valid`  in  1  read beat valid.
- `o_rd_data_ready`  out  1  read beat accepted.
- `o_cvt_bytes`  out  2·QUAN_BITS  data to converter.
- `o_cvt_valid`  out  1  converter input valid.
- `i_cvt_ready`  in  1  converter input ready.
- `i_pix_valid`, `i_pix_ready`  in  1 each  converter output handshake (monitored only).

## Operation
- **Word total:** total words W = `i_pix_num`·3/2, computed at start and held in a CNT_W+1-bit register.
- **Start rejection:** an odd `i_pix_num` is rejected. `o_err` pulses, the FSM stays in IDLE and no request is issued.
- **Zero pixels:** `i_pix_num` = 0 goes straight to DONE.
- **FSM states:**
  - IDLE → REQ on a valid start.
  - REQ: hold the request until `i_rd_req_ready`.
    - → WAIT if words remain unrequested.
    - → DRAIN if the last request was issued.
  - WAIT → REQ when outstanding < MAX_OUTSTANDING.
  - DRAIN → DONE when pixel count = `i_pix_num` and outstanding = 0.
  - DONE → IDLE after one cycle.
- **Request sizing:**
  - len = min(BURST_LEN, remaining unrequested words).
  - addr = base + 2·(words already requested).
  - The last burst is short when W mod BURST_LEN ≠ 0.
- **Outstanding counter:**
  - +1 on request handshake; −1 when the final beat of the oldest burst is accepted.
  - Both in the same cycle → unchanged.
  - Beat counter tracks the oldest burst; burst lengths are held in a MAX_OUTSTANDING-deep length FIFO.
- **Data path:** combinational pass-through, gated by `o_busy`.
  - `o_cvt_bytes` = `i_rd_data`.
  - `o_cvt_valid` = `i_rd_data_valid` & busy.
  - `o_rd_data_ready` = `i_cvt_ready` & busy.
- **Pixel counter:** increments on `i_pix_valid` & `i_pix_ready`.
- **Start while busy:** `i_start` is ignored.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, all counters 0.
- **Reset mid-operation:** immediate abort. No flush, and no `o_done`.
- **First request:** `o_rd_req_valid` is registered and rises the cycle after the accepted start.
- **Request stability:** addr/len/valid stay stable while valid is high and ready is low.
- **Back-to-back requests:** the next request is valid at the earliest one cycle after the previous handshake (via WAIT).
- **Completion:** `o_done` pulses the cycle after the last pixel handshake, provided outstanding = 0. `o_busy` falls the following cycle.
- **Start after completion:** a new start is accepted in the cycle after DONE.

## Structure
- **Shared package (hyper-parameter defines):** QUAN_BITS, BURST_LEN and MAX_OUTSTANDING defaults, plus the FSM state encoding (IDLE, REQ, WAIT, DRAIN, DONE).
- **Sub-module `rd_burst_gen`:** holds the remaining-word counter, next address and len computation.
- **Top level:** the FSM, outstanding/beat tracking, length FIFO and pixel counter stay in the top level.

## Test plan
1. pix_num=4, base=0x1000, all ready high → one request addr 0x1000 len 6; 6 beats forwarded; `o_done` 1 cycle after the 4th pixel handshake.
2. pix_num=22 → requests (0x1000,16), (0x1020,16), (0x1040,1); 33 beats total; 22 pixels counted; then `o_done`.
3. pix_num=64, MAX_OUTSTANDING=2, data held off → exactly 2 requests issued. The third appears only after the 16th beat of the first burst is accepted.
4. `i_rd_req_ready` low 5 cycles, `i_cvt_ready` toggling → addr/len stable, no beat lost or duplicated; pixel count and `o_done` correct.
5. pix_num=5 → `o_err` pulse, no request, `o_busy` stays 0. Then pix_num=0 → `o_done` with no request.
6. `s_rst` during the second burst of case 2 → all outputs 0 next edge. A fresh start with pix_num=4 then completes as in case 1.
